// File: rtl/xbox_xlr_line_mover_if.sv
// Accelerator-port bundle for the XBOX line mover: command, status and per-instance memory bus.
interface xbox_xlr_line_mover_if #(
  parameter int unsigned NUM_MEMS           = 2,
  parameter int unsigned LOG2_LINES_PER_MEM = 8
);
  localparam int unsigned LL     = LOG2_LINES_PER_MEM;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BE_W   = 32;

  // command side
  logic                   start;
  logic                   mode;
  logic [3:0]             src_mem;
  logic [LL-1:0]          src_line;
  logic [3:0]             dst_mem;
  logic [LL-1:0]          dst_line;
  logic [LL:0]            num_lines;
  logic [31:0]            fill_word;

  // status side
  logic                   busy;
  logic                   done;
  logic                   err;

  // memory farm side
  logic [NUM_MEMS-1:0][LL-1:0]     xlr_mem_addr;
  logic [NUM_MEMS-1:0][LINE_W-1:0] xlr_mem_wdata;
  logic [NUM_MEMS-1:0][BE_W-1:0]   xlr_mem_be;
  logic [NUM_MEMS-1:0]             xlr_mem_rd;
  logic [NUM_MEMS-1:0]             xlr_mem_wr;
  logic [NUM_MEMS-1:0][LINE_W-1:0] xlr_mem_rdata;

  // line mover view
  modport master (
    input  start, mode, src_mem, src_line, dst_mem, dst_line, num_lines, fill_word,
    output busy, done, err,
    output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    input  xlr_mem_rdata
  );

  // command source plus memory farm view
  modport slave (
    output start, mode, src_mem, src_line, dst_mem, dst_line, num_lines, fill_word,
    input  busy, done, err,
    input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    output xlr_mem_rdata
  );
endinterface

// File: rtl/xbox_xlr_line_mover.sv
// Accelerator-side line mover: copies or fills runs of 256-bit lines across the memory farm.
module xbox_xlr_line_mover #(
  parameter int unsigned NUM_MEMS           = 2,
  parameter int unsigned LOG2_LINES_PER_MEM = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  xbox_xlr_line_mover_if.master bus
);
  localparam int unsigned LL        = LOG2_LINES_PER_MEM;
  localparam int unsigned CNT_W     = LL + 1;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned BE_W      = 32;
  localparam int unsigned MEM_IDX_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
  localparam logic [4:0]  NUM_MEMS_L = 5'(NUM_MEMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY_OVL,
    S_COPY_RD,
    S_COPY_WR,
    S_FILL,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                 mode;
    logic [MEM_IDX_W-1:0] src_sel;
    logic [MEM_IDX_W-1:0] dst_sel;
    logic [31:0]          fill_word;
  } cmd_t;

  state_t                        state_q, state_d;
  cmd_t                          cmd_q, cmd_d;
  logic [LL-1:0]                 src_line_q, src_line_d;
  logic [LL-1:0]                 dst_line_q, dst_line_d;
  logic [CNT_W-1:0]              rd_left_q, rd_left_d;
  logic [CNT_W-1:0]              wr_left_q, wr_left_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic [NUM_MEMS-1:0]           rd_q, rd_d;
  logic [NUM_MEMS-1:0]           wr_q, wr_d;
  logic [NUM_MEMS-1:0][LL-1:0]   addr_q, addr_d;
  logic [NUM_MEMS-1:0][BE_W-1:0] be_q, be_d;

  logic                 cmd_illegal;
  logic                 do_rd, do_wr;
  logic [MEM_IDX_W-1:0] rd_sel, wr_sel;
  logic [LL-1:0]        rd_line, wr_line;
  logic [LINE_W-1:0]    line_data;

  // A target outside the farm (or a copy source outside it) is rejected without any access.
  assign cmd_illegal = ({1'b0, bus.dst_mem} >= NUM_MEMS_L) ||
                       (!bus.mode && ({1'b0, bus.src_mem} >= NUM_MEMS_L));

  // State, counters and the registered per-cycle access description.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      src_line_q <= '0;
      dst_line_q <= '0;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      addr_q     <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      src_line_q <= src_line_d;
      dst_line_q <= dst_line_d;
      rd_left_q  <= rd_left_d;
      wr_left_q  <= wr_left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
    end
  end

  // Next state plus the access to present in the following cycle.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    src_line_d = src_line_q;
    dst_line_d = dst_line_q;
    rd_left_d  = rd_left_q;
    wr_left_d  = wr_left_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    do_rd      = 1'b0;
    do_wr      = 1'b0;
    rd_sel     = cmd_q.src_sel;
    wr_sel     = cmd_q.dst_sel;
    rd_line    = src_line_q;
    wr_line    = dst_line_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cmd_d.mode      = bus.mode;
          cmd_d.src_sel   = bus.mode ? '0 : MEM_IDX_W'(bus.src_mem);
          cmd_d.dst_sel   = MEM_IDX_W'(bus.dst_mem);
          cmd_d.fill_word = bus.fill_word;
          if (cmd_illegal || (bus.num_lines == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = cmd_illegal;
          end else begin
            busy_d     = 1'b1;
            rd_sel     = cmd_d.src_sel;
            wr_sel     = cmd_d.dst_sel;
            rd_line    = bus.src_line;
            wr_line    = bus.dst_line;
            src_line_d = bus.src_line + LL'(1);
            dst_line_d = bus.dst_line;
            rd_left_d  = bus.num_lines - CNT_W'(1);
            wr_left_d  = bus.num_lines;
            if (bus.mode) begin
              do_wr      = 1'b1;
              dst_line_d = bus.dst_line + LL'(1);
              wr_left_d  = bus.num_lines - CNT_W'(1);
              state_d    = S_FILL;
            end else begin
              do_rd   = 1'b1;
              state_d = (cmd_d.src_sel == cmd_d.dst_sel) ? S_COPY_RD : S_COPY_OVL;
            end
          end
        end
      end

      // Pipelined copy: write the line read last cycle while reading the next one.
      S_COPY_OVL: begin
        if (wr_left_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d     = 1'b1;
          do_wr      = 1'b1;
          dst_line_d = dst_line_q + LL'(1);
          wr_left_d  = wr_left_q - CNT_W'(1);
          if (rd_left_q != '0) begin
            do_rd      = 1'b1;
            src_line_d = src_line_q + LL'(1);
            rd_left_d  = rd_left_q - CNT_W'(1);
          end
        end
      end

      // Single-port instance: the read just issued is written back next cycle.
      S_COPY_RD: begin
        busy_d     = 1'b1;
        do_wr      = 1'b1;
        dst_line_d = dst_line_q + LL'(1);
        wr_left_d  = wr_left_q - CNT_W'(1);
        state_d    = S_COPY_WR;
      end

      S_COPY_WR: begin
        if (wr_left_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d     = 1'b1;
          do_rd      = 1'b1;
          src_line_d = src_line_q + LL'(1);
          state_d    = S_COPY_RD;
        end
      end

      S_FILL: begin
        if (wr_left_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d     = 1'b1;
          do_wr      = 1'b1;
          dst_line_d = dst_line_q + LL'(1);
          wr_left_d  = wr_left_q - CNT_W'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    rd_d   = '0;
    wr_d   = '0;
    addr_d = '0;
    be_d   = '0;
    if (do_rd) begin
      rd_d[rd_sel]   = 1'b1;
      addr_d[rd_sel] = rd_line;
    end
    if (do_wr) begin
      wr_d[wr_sel]   = 1'b1;
      addr_d[wr_sel] = wr_line;
      be_d[wr_sel]   = '1;
    end
  end

  // Copy data is the source read data passed straight through; fill data is the replicated word.
  assign line_data = cmd_q.mode ? {8{cmd_q.fill_word}} : bus.xlr_mem_rdata[cmd_q.src_sel];

  // Only the instance being written sees non-zero write data.
  for (genvar g = 0; g < NUM_MEMS; g++) begin : g_wdata
    assign bus.xlr_mem_wdata[g] = wr_q[g] ? line_data : '0;
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.xlr_mem_rd   = rd_q;
  assign bus.xlr_mem_wr   = wr_q;
  assign bus.xlr_mem_addr = addr_q;
  assign bus.xlr_mem_be   = be_q;
endmodule

// File: tb/tb_xbox_xlr_line_mover.sv
// Directed bench for xbox_xlr_line_mover with a behavioural two-instance memory farm.
module tb_xbox_xlr_line_mover;
  localparam int unsigned NM    = 2;
  localparam int unsigned LL    = 8;
  localparam int          LINES = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xbox_xlr_line_mover_if #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LL)) bus ();

  xbox_xlr_line_mover #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [NM-1:0] rd;
    logic [NM-1:0] wr;
    logic          busy;
    logic          done;
    logic          err;
  } cyc_t;

  typedef struct {
    int           m;
    int           l;
    logic [255:0] data;
  } wr_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_idx = 0;
  string tag = "";
  cyc_t exp_cyc[$];
  wr_t  exp_wr[$];

  logic [255:0] mem     [NM][LINES];
  logic [255:0] ref_mem [NM][LINES];
  logic [NM-1:0][255:0] rdata_q;
  logic         pl_en = 1'b0;
  int           pl_m, pl_l;
  logic [255:0] pl_data;

  // Memory farm model: read data one cycle after rd, writes land at the edge.
  always @(posedge clk) begin
    if (pl_en) mem[pl_m][pl_l] <= pl_data;
    for (int i = 0; i < NM; i++) begin
      if (bus.xlr_mem_wr[i]) mem[i][bus.xlr_mem_addr[i]] <= bus.xlr_mem_wdata[i];
      if (bus.xlr_mem_rd[i]) rdata_q[i] <= mem[i][bus.xlr_mem_addr[i]];
    end
  end
  assign bus.xlr_mem_rdata = rdata_q;

  // Write monitor: lane hygiene each cycle, and every write popped against the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n) begin
      for (int i = 0; i < NM; i++) begin
        n_tests++;
        assert (bus.xlr_mem_be[i] === (bus.xlr_mem_wr[i] ? 32'hFFFF_FFFF : 32'h0) &&
                (bus.xlr_mem_rd[i] || bus.xlr_mem_wr[i] || bus.xlr_mem_addr[i] === '0) &&
                (bus.xlr_mem_wr[i] || bus.xlr_mem_wdata[i] === '0) &&
                !(bus.xlr_mem_rd[i] && bus.xlr_mem_wr[i]))
        else begin
          n_fail++;
          $error("FAIL lane_mem%0d: observed rd=%b wr=%b addr=%0d be=%h, required be=%h and zero addr/wdata when unaddressed",
                 i, bus.xlr_mem_rd[i], bus.xlr_mem_wr[i], bus.xlr_mem_addr[i], bus.xlr_mem_be[i],
                 bus.xlr_mem_wr[i] ? 32'hFFFF_FFFF : 32'h0);
        end
        if (bus.xlr_mem_wr[i]) begin
          n_tests++;
          if (exp_wr.size() == 0) begin
            n_fail++;
            $error("FAIL %s_unexpected_wr: observed write mem%0d line %0d, required no write", tag, i, bus.xlr_mem_addr[i]);
          end else begin
            e = exp_wr.pop_front();
            assert (e.m == i && e.l == int'(bus.xlr_mem_addr[i]) && bus.xlr_mem_wdata[i] === e.data)
            else begin
              n_fail++;
              $error("FAIL %s_wr: observed mem%0d line %0d data %h, required mem%0d line %0d data %h",
                     tag, i, bus.xlr_mem_addr[i], bus.xlr_mem_wdata[i], e.m, e.l, e.data);
            end
          end
        end
      end
    end
  end

  function automatic logic [255:0] pat(input int m, input int l, input int salt);
    logic [255:0] r;
    for (int w = 0; w < 8; w++)
      r[w*32 +: 32] = 32'hC0DE_0000 ^ 32'(m << 12) ^ 32'(l << 4) ^ 32'(w) ^ 32'(salt << 20);
    return r;
  endfunction

  task automatic preload_range(input int m, input int first, input int cnt, input int salt);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_m    = m;
      pl_l    = (first + k) % LINES;
      pl_data = pat(m, pl_l, salt);
      ref_mem[m][pl_l] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Expected per-cycle strobes/status from the command timing, starting at cycle 1.
  task automatic push_trace(input bit mode, input int s, input int d, input int n, input int tail);
    bit   illegal;
    cyc_t c;
    illegal = (d >= NM) || (!mode && s >= NM);
    if (illegal || n == 0) begin
      c = '0; c.done = 1'b1; c.err = illegal; exp_cyc.push_back(c);
    end else begin
      if (mode) begin
        for (int k = 0; k < n; k++) begin
          c = '0; c.wr[d] = 1'b1; c.busy = 1'b1; exp_cyc.push_back(c);
        end
      end else if (s != d) begin
        c = '0; c.rd[s] = 1'b1; c.busy = 1'b1; exp_cyc.push_back(c);
        for (int k = 1; k < n; k++) begin
          c = '0; c.rd[s] = 1'b1; c.wr[d] = 1'b1; c.busy = 1'b1; exp_cyc.push_back(c);
        end
        c = '0; c.wr[d] = 1'b1; c.busy = 1'b1; exp_cyc.push_back(c);
      end else begin
        for (int k = 0; k < n; k++) begin
          c = '0; c.rd[s] = 1'b1; c.busy = 1'b1; exp_cyc.push_back(c);
          c = '0; c.wr[d] = 1'b1; c.busy = 1'b1; exp_cyc.push_back(c);
        end
      end
      c = '0; c.done = 1'b1; exp_cyc.push_back(c);
    end
    for (int k = 0; k < tail; k++) exp_cyc.push_back(cyc_t'('0));
  endtask

  // Expected writes in ascending order, applied to the reference memory as they are queued.
  task automatic push_writes(input bit mode, input int s, input int sl, input int d, input int dl,
                             input int n, input logic [31:0] fill, input int maxw);
    wr_t w;
    if ((d >= NM) || (!mode && s >= NM) || n == 0) return;
    for (int k = 0; k < n && k < maxw; k++) begin
      w.m    = d;
      w.l    = (dl + k) % LINES;
      w.data = mode ? {8{fill}} : ref_mem[s][(sl + k) % LINES];
      ref_mem[d][w.l] = w.data;
      exp_wr.push_back(w);
    end
  endtask

  // Pulse start for one edge, then scramble the fields; returns in cycle 1.
  task automatic issue(input bit mode, input int s, input int sl, input int d, input int dl,
                       input int n, input logic [31:0] fill);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mode      = mode;
    bus.src_mem   = 4'(s);
    bus.src_line  = LL'(sl);
    bus.dst_mem   = 4'(d);
    bus.dst_line  = LL'(dl);
    bus.num_lines = (LL+1)'(n);
    bus.fill_word = fill;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.mode      = ~mode;
    bus.src_line  = LL'($urandom);
    bus.dst_line  = LL'($urandom);
    bus.num_lines = (LL+1)'($urandom_range(1, 200));
    bus.fill_word = $urandom;
    cyc_idx       = 1;
  endtask

  task automatic check_one();
    cyc_t e, g;
    n_tests++;
    g = {bus.xlr_mem_rd, bus.xlr_mem_wr, bus.busy, bus.done, bus.err};
    if (exp_cyc.size() == 0) begin
      n_fail++;
      $error("FAIL %s_trace_underflow: observed cycle %0d with no expected entry, required an entry", tag, cyc_idx);
    end else begin
      e = exp_cyc.pop_front();
      assert (g === e)
      else begin
        n_fail++;
        $error("FAIL %s_cycle%0d: observed rd=%b wr=%b busy=%b done=%b err=%b, required rd=%b wr=%b busy=%b done=%b err=%b",
               tag, cyc_idx, g.rd, g.wr, g.busy, g.done, g.err, e.rd, e.wr, e.busy, e.done, e.err);
      end
    end
  endtask

  task automatic check_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      check_one();
      @(negedge clk);
      cyc_idx++;
    end
  endtask

  task automatic check_mem(input int m, input int first, input int cnt);
    int l;
    for (int k = 0; k < cnt; k++) begin
      l = (first + k) % LINES;
      n_tests++;
      assert (mem[m][l] === ref_mem[m][l])
      else begin
        n_fail++;
        $error("FAIL %s_mem%0d_line%0d: observed %h, required %h", tag, m, l, mem[m][l], ref_mem[m][l]);
      end
    end
    n_tests++;
    assert (exp_wr.size() == 0)
    else begin
      n_fail++;
      $error("FAIL %s_writes_missing: observed %0d writes outstanding, required 0", tag, exp_wr.size());
    end
  endtask

  task automatic check_quiet(input string what);
    n_tests++;
    assert (bus.busy === 1'b0 && bus.done === 1'b0 && bus.err === 1'b0 &&
            bus.xlr_mem_rd === '0 && bus.xlr_mem_wr === '0 && bus.xlr_mem_addr === '0 &&
            bus.xlr_mem_be === '0 && bus.xlr_mem_wdata === '0)
    else begin
      n_fail++;
      $error("FAIL %s: observed busy=%b done=%b err=%b rd=%b wr=%b, required all outputs 0",
             what, bus.busy, bus.done, bus.err, bus.xlr_mem_rd, bus.xlr_mem_wr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_mem = '0; bus.src_line = '0;
    bus.dst_mem = '0; bus.dst_line = '0; bus.num_lines = '0; bus.fill_word = '0;
    #12;
    check_quiet("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Copy across instances with overlapped read/write.
    tag = "copy_x";
    preload_range(0, 4, 4, 1);
    preload_range(1, 9, 6, 2);
    push_trace(1'b0, 0, 1, 4, 1);
    push_writes(1'b0, 0, 4, 1, 10, 4, 32'h0, 99);
    issue(1'b0, 0, 4, 1, 10, 4, 32'h0);
    check_cycles(7);
    check_mem(1, 9, 6);

    // Same-instance copy alternates read and write.
    tag = "copy_same";
    preload_range(0, 0, 3, 3);
    preload_range(0, 100, 4, 4);
    push_trace(1'b0, 0, 0, 3, 1);
    push_writes(1'b0, 0, 0, 0, 100, 3, 32'h0, 99);
    issue(1'b0, 0, 0, 0, 100, 3, 32'h0);
    check_cycles(8);
    check_mem(0, 100, 4);

    // Fill wrapping past the last line.
    tag = "fill_wrap";
    preload_range(1, 253, 6, 5);
    push_trace(1'b1, 0, 1, 4, 1);
    push_writes(1'b1, 0, 0, 1, 254, 4, 32'hDEAD_BEEF, 99);
    issue(1'b1, 0, 0, 1, 254, 4, 32'hDEAD_BEEF);
    check_cycles(6);
    check_mem(1, 253, 6);

    // Illegal and empty commands.
    tag = "ill_dst";
    push_trace(1'b0, 0, 2, 3, 2);
    issue(1'b0, 0, 0, 2, 0, 3, 32'h0);
    check_cycles(3);
    tag = "ill_src";
    push_trace(1'b0, 3, 0, 2, 2);
    issue(1'b0, 3, 0, 0, 0, 2, 32'h0);
    check_cycles(3);
    tag = "ill_fill";
    push_trace(1'b1, 0, 15, 2, 2);
    issue(1'b1, 0, 0, 15, 0, 2, 32'h1111_2222);
    check_cycles(3);
    tag = "empty";
    push_trace(1'b0, 0, 1, 0, 2);
    issue(1'b0, 0, 0, 1, 0, 0, 32'h0);
    check_cycles(3);
    check_mem(1, 9, 6);
    tag = "fill_src_ignored";
    push_trace(1'b1, 9, 0, 1, 1);
    push_writes(1'b1, 9, 0, 0, 5, 1, 32'h0BAD_F00D, 99);
    issue(1'b1, 9, 0, 0, 5, 1, 32'h0BAD_F00D);
    check_cycles(3);
    check_mem(0, 4, 4);

    // Second start during a copy is ignored.
    tag = "start_busy";
    preload_range(0, 20, 4, 6);
    push_trace(1'b0, 1, 0, 4, 2);
    push_writes(1'b0, 1, 9, 0, 20, 4, 32'h0, 99);
    issue(1'b0, 1, 9, 0, 20, 4, 32'h0);
    check_cycles(2);
    bus.start = 1'b1; bus.mode = 1'b1; bus.dst_mem = 4'd1; bus.dst_line = '0;
    bus.num_lines = (LL+1)'(1); bus.fill_word = 32'h5555_AAAA;
    check_cycles(1);
    bus.start = 1'b0;
    check_cycles(exp_cyc.size());
    check_mem(0, 20, 4);
    check_mem(1, 0, 2);

    // Reset mid-copy: two lines land, the rest stay as they were.
    tag = "reset_mid";
    preload_range(0, 40, 4, 7);
    push_trace(1'b0, 1, 0, 4, 0);
    push_writes(1'b0, 1, 10, 0, 40, 4, 32'h0, 2);
    issue(1'b0, 1, 10, 0, 40, 4, 32'h0);
    check_cycles(2);
    check_one();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_quiet("reset_mid_async");
    exp_cyc.delete();
    @(negedge clk);
    check_quiet("reset_mid_held");
    rst_n = 1'b1;
    check_mem(0, 40, 4);

    // New command after reset.
    tag = "after_reset";
    push_trace(1'b1, 0, 0, 2, 1);
    push_writes(1'b1, 0, 0, 0, 42, 2, 32'h1234_5678, 99);
    issue(1'b1, 0, 0, 0, 42, 2, 32'h1234_5678);
    check_cycles(4);
    check_mem(0, 40, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
